// File: rtl/value_entry_ctrl.sv
// Push-button value entry: sync, debounce, auto-repeat inc/dec edit,
// and a valid/ready commit of the edited value to the consumer.
module value_entry_ctrl #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             btn_commit,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             editing,
  output logic             commit_valid,
  output logic [WIDTH-1:0] commit_value,
  input  logic             commit_ready
);

  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [TW-1:0] H_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] R_LAST = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [WIDTH-1:0] V_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  // bit 0 = inc, bit 1 = dec, bit 2 = commit
  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    lvl;
  logic [2:0]    lvl_q;
  logic [2:0]    rise;
  logic [DW-1:0] cnt [3];

  state_t        state;
  logic [TW-1:0] timer;
  logic          dir_dec;
  logic          act_lvl;
  logic          oth_lvl;
  logic          start_inc;
  logic          start_dec;
  logic [WIDTH-1:0] stepped;

  assign raw = {btn_commit, btn_dec, btn_inc};

  // two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // debounce: level follows input only after a full run of disagreement
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl   <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      lvl_q <= lvl;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] != lvl[i]) begin
          if (cnt[i] == D_LAST) begin
            lvl[i] <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + D_ONE;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // edge detect and per-direction qualifiers for the step FSM
  always_comb begin
    rise      = lvl & ~lvl_q;
    start_inc = rise[0] & ~lvl[1];
    start_dec = rise[1] & ~lvl[0];
    act_lvl   = dir_dec ? lvl[1] : lvl[0];
    oth_lvl   = dir_dec ? lvl[0] : lvl[1];
    stepped   = dir_dec ? value - V_ONE : value + V_ONE;
  end

  // step FSM: first step on press, then hold delay, then auto-repeat
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      dir_dec <= 1'b0;
      value   <= '0;
      editing <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      timer   <= '0;
      value   <= '0;
      editing <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_inc | start_dec) begin
            dir_dec <= start_dec;
            value   <= start_dec ? value - V_ONE
                                 : value + V_ONE;
            timer   <= '0;
            state   <= HOLD;
            editing <= 1'b1;
          end
        end
        HOLD: begin
          if (!act_lvl || oth_lvl) begin
            state   <= IDLE;
            timer   <= '0;
            editing <= 1'b0;
          end else if (timer == H_LAST) begin
            value <= stepped;
            timer <= '0;
            state <= REPEAT;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        REPEAT: begin
          if (!act_lvl || oth_lvl) begin
            state   <= IDLE;
            timer   <= '0;
            editing <= 1'b0;
          end else if (timer == R_LAST) begin
            value <= stepped;
            timer <= '0;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          timer   <= '0;
          editing <= 1'b0;
        end
      endcase
    end
  end

  // commit offer: latch on press, hold until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_value <= '0;
    end else if (commit_valid) begin
      if (commit_ready) commit_valid <= 1'b0;
    end else if (rise[2]) begin
      commit_valid <= 1'b1;
      commit_value <= value;
    end
  end

endmodule

// File: tb/tb_value_entry_ctrl.sv
// Scoreboard bench for value_entry_ctrl: directed scenarios plus random
// button traffic checked against a behavioural model.
module tb_value_entry_ctrl;

  localparam int W = 8;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_inc;
  logic         btn_dec;
  logic         btn_commit;
  logic         clear;
  logic         commit_ready;
  logic [W-1:0] value;
  logic [W-1:0] commit_value;
  logic         editing;
  logic         commit_valid;

  int total = 0;
  int bad   = 0;

  value_entry_ctrl #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .btn_commit(btn_commit),
    .clear(clear),
    .value(value),
    .editing(editing),
    .commit_valid(commit_valid),
    .commit_value(commit_value),
    .commit_ready(commit_ready)
  );

  always #5 clk = ~clk;

  // behavioural model state
  bit           m_s1 [3];
  bit           m_s2 [3];
  bit           m_hist [3][D];
  bit           m_lvl [3];
  bit           m_lvl_q [3];
  bit           m_rise [3];
  bit           m_active;
  bit           m_dec;
  int           m_el;
  logic [W-1:0] m_val;
  logic [W-1:0] m_v0;
  logic [W-1:0] m_cval;
  bit           m_cvalid;
  bit           m_act;
  bit           m_oth;
  bit           m_all;
  bit           m_raw [3];
  logic [W-1:0] exp_q [$];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // one clock of the model, using the inputs that were stable before the edge
  task automatic model_step();
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_lvl_q[b] = 0;
        for (int k = 0; k < D; k++) m_hist[b][k] = 0;
      end
      m_active = 0; m_dec = 0; m_el = 0;
      m_val = '0; m_cval = '0; m_cvalid = 0;
      exp_q.delete();
      return;
    end
    m_raw[0] = btn_inc; m_raw[1] = btn_dec; m_raw[2] = btn_commit;
    for (int b = 0; b < 3; b++) m_rise[b] = m_lvl[b] && !m_lvl_q[b];
    m_v0 = m_val;
    if (clear) begin
      m_val = '0;
      m_active = 0;
    end else if (!m_active) begin
      if (m_rise[0] && !m_lvl[1]) begin
        m_active = 1; m_dec = 0; m_el = 0; m_val = m_val + 1;
      end else if (m_rise[1] && !m_lvl[0]) begin
        m_active = 1; m_dec = 1; m_el = 0; m_val = m_val - 1;
      end
    end else begin
      m_act = m_dec ? m_lvl[1] : m_lvl[0];
      m_oth = m_dec ? m_lvl[0] : m_lvl[1];
      if (!m_act || m_oth) begin
        m_active = 0;
      end else begin
        m_el++;
        if (m_el == H || (m_el > H && (m_el - H) % R == 0))
          m_val = m_dec ? m_val - 1 : m_val + 1;
      end
    end
    if (m_cvalid) begin
      if (commit_ready) m_cvalid = 0;
    end else if (m_rise[2]) begin
      m_cvalid = 1;
      m_cval = m_v0;
      exp_q.push_back(m_v0);
    end
    for (int b = 0; b < 3; b++) begin
      m_lvl_q[b] = m_lvl[b];
      for (int k = D - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
      m_hist[b][0] = m_s2[b];
      m_all = 1;
      for (int k = 0; k < D; k++)
        if (m_hist[b][k] == m_lvl[b]) m_all = 0;
      if (m_all) m_lvl[b] = m_hist[b][0];
      m_s2[b] = m_s1[b];
      m_s1[b] = m_raw[b];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #2;
    end
  endtask

  // monitor: per-cycle state compare and commit handshake scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("value", value, m_val);
        chk("editing", editing, m_active);
        chk("commit_valid", commit_valid, m_cvalid);
        if (commit_valid)
          chk("commit_hold", commit_value, m_cval);
        if (commit_valid && commit_ready) begin
          if (exp_q.size() == 0) begin
            chk("commit_unexpected", 1, 0);
          end else begin
            chk("commit_xfer", commit_value, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1; btn_inc = 0; btn_dec = 0; btn_commit = 0;
    clear = 0; commit_ready = 0;
    tick(3);
    rst = 0;
    tick(1);
    chk("rst_value", value, 0);
    chk("rst_valid", commit_valid, 0);
    chk("rst_editing", editing, 0);

    // bouncing contact must not step
    for (int i = 0; i < 10; i++) begin
      btn_inc = ~btn_inc;
      tick(2);
    end
    btn_inc = 0;
    tick(12);
    chk("bounce", value, 0);

    // clean press: one step, 2+D+1 cycles after press
    btn_inc = 1;
    tick(6);
    chk("lat_before", value, 0);
    tick(1);
    chk("lat_step", value, 1);
    tick(3);
    btn_inc = 0;
    tick(12);
    chk("one_step", value, 1);

    // auto-repeat: steps at t=0,20,25,...,65 before release takes effect
    btn_inc = 1;
    tick(66);
    btn_inc = 0;
    tick(12);
    chk("repeat_val", value, 12);
    chk("repeat_edit", editing, 0);

    // wrap both ways
    clear = 1; tick(1); clear = 0; tick(1);
    chk("clear_val", value, 0);
    btn_dec = 1; tick(10); btn_dec = 0; tick(12);
    chk("wrap_dec", value, 8'hFF);
    btn_inc = 1; tick(10); btn_inc = 0; tick(12);
    chk("wrap_inc", value, 8'h00);

    // inc held into repeat, then dec joins: stepping stops
    btn_inc = 1; tick(36);
    btn_dec = 1; tick(20);
    chk("simul_idle", editing, 0);
    tick(20);
    btn_inc = 0; btn_dec = 0; tick(12);
    chk("simul_edit", editing, 0);

    // build value 42: 1 + 1 + 40 repeats, release lands before step 43
    clear = 1; tick(1); clear = 0;
    btn_inc = 1; tick(223); btn_inc = 0; tick(12);
    chk("build42", value, 42);

    // commit 42 while editing continues with ready low
    btn_commit = 1; btn_inc = 1;
    tick(10);
    btn_commit = 0;
    chk("cm_valid", commit_valid, 1);
    chk("cm_value", commit_value, 42);
    tick(10);
    btn_commit = 1; tick(10); btn_commit = 0;
    tick(10);
    btn_inc = 0; tick(12);
    chk("cm_stable", commit_value, 42);
    chk("cm_one", exp_q.size(), 1);
    clear = 1; tick(1); clear = 0; tick(1);
    chk("cm_clr_val", value, 0);
    chk("cm_clr_cv", commit_value, 42);
    chk("cm_clr_vld", commit_valid, 1);
    commit_ready = 1; tick(1); commit_ready = 0;
    tick(1);
    chk("cm_drop", commit_valid, 0);
    chk("cm_drained", exp_q.size(), 0);

    // random traffic
    for (int i = 0; i < 120; i++) begin
      btn_inc      = ($urandom_range(0, 2) == 0);
      btn_dec      = ($urandom_range(0, 3) == 0);
      btn_commit   = ($urandom_range(0, 4) == 0);
      commit_ready = ($urandom_range(0, 2) == 0);
      clear        = ($urandom_range(0, 25) == 0);
      tick(1);
      clear = 0;
      tick($urandom_range(0, 40));
    end
    btn_inc = 0; btn_dec = 0; btn_commit = 0; commit_ready = 1;
    tick(20);
    chk("end_drained", exp_q.size(), 0);
    chk("end_idle", editing, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
